// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then shifts one
// command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [10:0]     frame_q, frame_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic            clk_oe_d, data_oe_d, busy_d, done_d, err_d;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fe;
    logic timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fe      = clk_prev & ~clk_s2;
    assign timeout = (cnt_q == ToLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_q     <= '0;
            bit_idx_q   <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            bit_idx_q   <= bit_idx_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (tx_start) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data, 1'b0};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                clk_oe_d = 1'b1;
                if (cnt_q == InhLast) begin
                    data_oe_d = 1'b1;
                    state_d   = StReq;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReq: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                data_oe_d = ~frame_q[0];
                state_d   = StSend;
            end
            StSend: begin
                cnt_d     = cnt_q + 1'b1;
                data_oe_d = ~frame_q[0];
                if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end else if (fe) begin
                    frame_d   = {1'b1, frame_q[10:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    data_oe_d = ~frame_d[0];
                    // Edge 10 puts the stop bit (released line) out; the ACK phase follows.
                    if (bit_idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (fe) begin
                    if (!data_s2) begin
                        state_d = StWaitIdle;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (clk_s2 && data_s2) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a small PS/2 device model clocks frames out of the host
// and replays a table of command bytes, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

    localparam int unsigned Inh = 5000;
    localparam int unsigned To  = 2000;
    localparam int unsigned Hp  = 40;  // device clock half period in system clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk, dev_data;
    logic       ps2_clk_line, ps2_data_line;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(To)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        poke;
        logic [10:0] exp_frame;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
        check({tag, "_data_oe"}, 32'(ps2_data_oe), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Called on the first INHIBIT sample; returns on the first SEND sample.
    task automatic check_request();
        int n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < int'(Inh) + 100) begin
            n++;
            tick();
        end
        check("inhibit_len", 32'(n), 32'(Inh));
        check("req_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("req_data_oe", 32'(ps2_data_oe), 32'd1);
        tick();
        check("send_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("send_start_bit", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device clocks nedges edges, sampling the line on each rising edge.
    task automatic device_bits(input int nedges, input logic poke, output logic [10:0] bits);
        bits    = '0;
        bits[0] = ps2_data_line;
        for (int k = 1; k <= nedges; k++) begin
            repeat (Hp) tick();
            dev_clk = 1'b0;
            repeat (Hp) tick();
            dev_clk = 1'b1;
            bits[k] = ps2_data_line;
            if (poke && k == 4) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
        end
    endtask

    task automatic device_ack(input logic ack, output int nd, output int ne, output int nb);
        nd = 0;
        ne = 0;
        nb = 0;
        repeat (Hp / 2) tick();
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (Hp / 2) tick();
        dev_clk = 1'b0;
        for (int i = 0; i < 4 * int'(Hp); i++) begin
            if (i == int'(Hp)) begin
                dev_clk  = 1'b1;
                dev_data = 1'b1;
            end
            tick();
            if (done) nd++;
            if (err) ne++;
            if (done && err) nb++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [10:0] bits;
        int nd, ne, nb;
        start_tx(v.data);
        check_request();
        device_bits(10, v.poke, bits);
        check("frame_bits", 32'(bits), 32'(v.exp_frame));
        device_ack(v.ack, nd, ne, nb);
        check("done_pulses", 32'(nd), 32'(v.exp_done));
        check("err_pulses", 32'(ne), 32'(v.exp_err));
        check("done_err_exclusive", 32'(nb), 32'd0);
        check_idle_outputs("post_frame");
    endtask

    initial begin
        logic [10:0] bits;
        int n;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 11'h7DA, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 11'h600, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 11'h402, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 11'h7FE, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 11'h74A, 1'b0, 1'b1};

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        check_idle_outputs("in_reset");
        rst = 1'b0;
        repeat (2) tick();
        check_idle_outputs("after_reset");

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (10) tick();
        end

        // Device never clocks: timeout counts from SEND entry.
        start_tx(8'hFF);
        check_request();
        n = 0;
        while (!err && n < int'(To) + 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(To));
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_done", 32'(done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        tick();
        check("timeout_err_one_cycle", 32'(err), 32'd0);
        run_vec(vecs[0]);

        // Reset after the fourth device edge; 0x33 has data bit 3 low so data_oe is asserted.
        start_tx(8'h33);
        check_request();
        device_bits(4, 1'b0, bits);
        repeat (5) tick();
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("mid_frame_reset");
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        run_vec(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
